// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared core definitions: fetch state encoding, reset PC default and
// word-alignment helper. Also imported by the LSU bus logic.
package ifu_fetch_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        NPC   = 3'd4,
        ERR   = 3'd5
    } fetch_state_e;

    // True when the address can be used for a 32-bit instruction fetch.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_timeout_ctr.sv
// Cycle counter bounding how long a single fetch may stay in flight.
// Held at zero while clear is high; saturates at LIMIT-1 and reports
// expiry while enabled.
module ifu_fetch_ctrl_timeout_ctr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // Count enabled cycles; stop at the last value so expiry stays asserted.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch controller: one outstanding request to
// instruction memory, one instruction presented to decode, then wait for
// the next PC from execute before fetching again.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 1024,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop,
    input  logic [31:0]      next_pc,
    input  logic             next_pc_valid,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_rsp_valid,
    output logic             mem_rsp_ready,
    input  logic [31:0]      mem_rsp_data,
    input  logic             mem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      pc,
    output logic [31:0]      inst,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_e state;
    fetch_state_e state_next;

    logic load_inst;
    logic set_err;
    logic redirect;
    logic deliver;
    logic in_flight;
    logic tmo_expired;

    // The timeout only runs while a fetch is in flight and is held at zero
    // otherwise, so every new fetch starts from a fresh count.
    assign in_flight = (state == REQ) || (state == WAIT);

    ifu_fetch_ctrl_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_flight),
        .enable  (in_flight),
        .expired (tmo_expired)
    );

    assign mem_req_addr = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. In REQ an expired timeout wins over a
    // late request handshake; in WAIT an arriving response wins over expiry.
    always_comb begin
        state_next    = state;
        load_inst     = 1'b0;
        set_err       = 1'b0;
        redirect      = 1'b0;
        deliver       = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        inst_valid    = 1'b0;

        case (state)
            IDLE: begin
                if (!stop) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (tmo_expired) begin
                    set_err    = 1'b1;
                    state_next = ERR;
                end else if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        set_err    = 1'b1;
                        state_next = ERR;
                    end else begin
                        load_inst  = 1'b1;
                        state_next = VALID;
                    end
                end else if (tmo_expired) begin
                    set_err    = 1'b1;
                    state_next = ERR;
                end
            end
            VALID: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    deliver = 1'b1;
                    if (next_pc_valid) begin
                        redirect = 1'b1;
                    end else begin
                        state_next = NPC;
                    end
                end
            end
            NPC: begin
                if (next_pc_valid) begin
                    redirect = 1'b1;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (redirect) begin
            if (!is_word_aligned(next_pc)) begin
                set_err    = 1'b1;
                state_next = ERR;
            end else if (stop) begin
                state_next = IDLE;
            end else begin
                state_next = REQ;
            end
        end
    end

    // Datapath registers: PC, captured instruction, sticky fault, delivery count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inst        <= '0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (redirect) begin
                pc <= next_pc;
            end
            if (load_inst) begin
                inst <= mem_rsp_data;
            end
            if (set_err) begin
                fetch_err <= 1'b1;
            end
            if (deliver) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: the bench plays memory and decode,
// keeps a word-addressed memory image and the expected PC/instruction/count.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TMO    = 16;

    logic        clk;
    logic        rst;
    logic        stop;
    logic [31:0] next_pc;
    logic        next_pc_valid;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fetch_err;
    logic [31:0] fetch_count;

    int total = 0;
    int bad = 0;
    int exp_count = 0;
    logic [31:0] mem [logic [31:0]];

    ifu_fetch_ctrl #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stop          (stop),
        .next_pc       (next_pc),
        .next_pc_valid (next_pc_valid),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .pc            (pc),
        .inst          (inst),
        .fetch_err     (fetch_err),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic memWord(input logic [31:0] a, output logic [31:0] d);
        if (!mem.exists(a)) mem[a] = $urandom;
        d = mem[a];
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pc"}, pc, RST_PC);
        checkOutput({tag, "_inst"}, inst, 0);
        checkOutput({tag, "_hs"}, {mem_req_valid, mem_rsp_ready, inst_valid}, 0);
        checkOutput({tag, "_err"}, fetch_err, 0);
        checkOutput({tag, "_count"}, fetch_count, 0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        stop = 1'b0;
        next_pc_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
        inst_ready = 1'b0;
        tick();
        tick();
        checkResetState("reset");
        rst = 1'b0;
        exp_count = 0;
    endtask

    // Wait for the request, check address held through stalls, then accept it.
    task automatic reqPhase(input logic [31:0] exp_pc, input int stall);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("req_seen", mem_req_valid, 1);
        checkOutput("req_addr", mem_req_addr, exp_pc);
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("req_hold", {mem_req_valid, mem_req_addr}, {1'b1, exp_pc});
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checkOutput("wait_state", {mem_req_valid, mem_rsp_ready}, 2'b01);
    endtask

    // Return the memory word after some idle cycles; instruction must appear next cycle.
    task automatic rspPhase(input logic [31:0] exp_pc, input int stall, output logic [31:0] d);
        memWord(exp_pc, d);
        for (int i = 0; i < stall; i++) begin
            mem_rsp_data = $urandom;
            tick();
            checkOutput("wait_hold", {mem_rsp_ready, inst_valid}, 2'b10);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_err = 1'b0;
        mem_rsp_data = d;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data = $urandom;
        checkOutput("inst_valid", inst_valid, 1);
        checkOutput("inst_data", inst, d);
        checkOutput("inst_pc", pc, exp_pc);
    endtask

    // Decode stalls, accepts, then execute supplies npc either in the same
    // cycle or later; checks the redirect outcome.
    task automatic decPhase(input logic [31:0] exp_pc, input logic [31:0] exp_inst, input int stall,
                            input logic [31:0] npc, input bit same);
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("dec_hold", {inst_valid, pc, inst}, {1'b1, exp_pc, exp_inst});
        end
        inst_ready = 1'b1;
        next_pc_valid = same;
        next_pc = same ? npc : $urandom;
        tick();
        inst_ready = 1'b0;
        next_pc_valid = 1'b0;
        exp_count++;
        checkOutput("count", fetch_count, exp_count);
        checkOutput("inst_drop", inst_valid, 0);
        if (!same) begin
            int k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) begin
                next_pc = $urandom;
                tick();
                checkOutput("npc_idle", {mem_req_valid, inst_valid}, 0);
            end
            next_pc_valid = 1'b1;
            next_pc = npc;
            tick();
            next_pc_valid = 1'b0;
        end
        checkOutput("redir_pc", pc, npc);
        if (npc[1:0] != 2'b00) begin
            checkOutput("misalign_err", fetch_err, 1);
            checkOutput("misalign_noreq", mem_req_valid, 0);
        end else begin
            checkOutput("redir_req", mem_req_valid, !stop);
            if (!stop) checkOutput("redir_addr", mem_req_addr, npc);
        end
    endtask

    function automatic logic [31:0] pickNext(input logic [31:0] cur);
        case ($urandom_range(0, 2))
            0: return cur + 32'd4;
            1: return cur + {20'd0, $urandom_range(0, 1023) * 4};
            default: return {$urandom} & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        logic [31:0] cur;
        logic [31:0] nxt;
        logic [31:0] d;
        bit rose;

        mem[RST_PC] = 32'h0000_0413;
        next_pc = '0;
        mem_rsp_data = '0;
        applyReset();

        // Zero-wait fetch from the reset PC, sequential redirect in the handshake cycle.
        cur = RST_PC;
        reqPhase(cur, 0);
        rspPhase(cur, 0, d);
        checkOutput("first_inst", inst, 32'h0000_0413);
        decPhase(cur, d, 0, 32'h8000_0004, 1'b1);
        cur = 32'h8000_0004;

        // Request stalled 3 cycles, decode stalled 2 cycles.
        reqPhase(cur, 3);
        rspPhase(cur, 0, d);
        nxt = pickNext(cur);
        decPhase(cur, d, 2, nxt, 1'b0);
        cur = nxt;

        // Random stalls and redirect timing.
        for (int it = 0; it < 16; it++) begin
            nxt = pickNext(cur);
            reqPhase(cur, $urandom_range(0, 3));
            rspPhase(cur, $urandom_range(0, 3), d);
            decPhase(cur, d, $urandom_range(0, 3), nxt, 1'($urandom_range(0, 1)));
            cur = nxt;
        end

        // Halt raised mid-fetch: instruction still delivered, no new request until released.
        nxt = pickNext(cur);
        reqPhase(cur, 0);
        stop = 1'b1;
        rspPhase(cur, 2, d);
        decPhase(cur, d, $urandom_range(0, 2), nxt, 1'($urandom_range(0, 1)));
        rose = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req_valid) rose = 1'b1;
        end
        checkOutput("stop_hold", rose, 0);
        stop = 1'b0;
        tick();
        checkOutput("stop_release", {mem_req_valid, mem_req_addr}, {1'b1, nxt});
        cur = nxt;

        // Reset pulsed while waiting for a response; a late response is ignored.
        reqPhase(cur, 1);
        tick();
        checkOutput("pre_rst_wait", mem_rsp_ready, 1);
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = $urandom;
        tick();
        checkResetState("midwait");
        rst = 1'b0;
        exp_count = 0;
        tick();
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("late_rsp_ignored", {inst_valid, inst, fetch_count}, 0);

        // Recover from the reset PC, then redirect to a misaligned target.
        cur = RST_PC;
        reqPhase(cur, 0);
        rspPhase(cur, 0, d);
        decPhase(cur, d, 0, 32'h8000_0102, 1'b1);
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_pc_valid = 1'b1;
            next_pc = 32'h8000_0200;
            tick();
            if (mem_req_valid) rose = 1'b1;
        end
        next_pc_valid = 1'b0;
        checkOutput("misalign_stays", {rose, fetch_err}, 2'b01);
        applyReset();

        // Memory fault on the response.
        cur = RST_PC;
        reqPhase(cur, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_err = 1'b1;
        mem_rsp_data = $urandom;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
        checkOutput("rsp_err_flag", fetch_err, 1);
        checkOutput("rsp_err_hs", {mem_req_valid, mem_rsp_ready, inst_valid}, 0);
        rose = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inst_ready = 1'b1;
            next_pc_valid = 1'b1;
            next_pc = RST_PC;
            tick();
            if (mem_req_valid || mem_rsp_ready || inst_valid) rose = 1'b1;
        end
        inst_ready = 1'b0;
        next_pc_valid = 1'b0;
        checkOutput("rsp_err_terminal", {rose, fetch_count}, 0);
        applyReset();

        // No response: fetch fails once TMO cycles have been spent in REQ plus WAIT.
        cur = RST_PC;
        reqPhase(cur, 0);
        repeat (TMO - 2) tick();
        checkOutput("tmo_not_yet", {fetch_err, mem_rsp_ready}, 2'b01);
        tick();
        checkOutput("tmo_fired", {fetch_err, mem_rsp_ready}, 2'b10);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = $urandom;
        tick();
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("tmo_late_rsp", {inst_valid, fetch_count, fetch_err}, {1'b0, 32'd0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
